// File: rtl/bat_memory_unit.sv
// Memory responder for the BatAmateur control-strobe bus: MAR plus RAM driven by
// the controller's strobes, with a byte-stream boot loader that packs pairs of
// bytes (high first) into RAM words while the CPU is held off the bus.
module bat_memory_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              MAR_LOAD,
  input  logic              MAR_EN,
  input  logic              RAM_RW,
  input  logic              RAM_EN,
  input  logic [DATA_W-1:0] BUS_IN,
  output logic [DATA_W-1:0] BUS_OUT,
  output logic              BUS_OE,
  input  logic              LD_MODE,
  input  logic              LD_VALID,
  input  logic [7:0]        LD_DATA,
  output logic              LD_READY,
  output logic [ADDR_W:0]   LD_WORDS,
  output logic              LD_WRAP,
  output logic              ERR_CONFLICT
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] WORDS_MAX = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {LD_IDLE, LD_HI, LD_LO, LD_WR} ld_state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] mar;
  logic [ADDR_W-1:0] ld_addr;
  logic [7:0]        hi_byte;
  logic [7:0]        lo_byte;
  ld_state_t         ld_state;
  ld_state_t         ld_state_nxt;

  logic              cpu_access;
  logic              cpu_rd;
  logic              cpu_wr;
  logic              ld_hs;
  logic              ld_wr;
  logic              err_set;
  logic [DATA_W-1:0] bus_val;

  // CPU strobes only count outside loader mode and outside reset.
  assign cpu_access = RST & ~LD_MODE & RAM_EN & MAR_EN;
  assign cpu_rd     = cpu_access & RAM_RW;
  assign cpu_wr     = cpu_access & ~RAM_RW;

  assign LD_READY = (ld_state == LD_HI) || (ld_state == LD_LO);
  assign ld_hs    = LD_MODE & LD_VALID & LD_READY;
  assign ld_wr    = LD_MODE & (ld_state == LD_WR);

  // Illegal combinations: any CPU strobe while the loader owns RAM, or a write
  // racing a MAR load (the write still lands at the old MAR).
  assign err_set = LD_MODE ? (RAM_EN | MAR_LOAD) : (cpu_wr & MAR_LOAD);

  // Zero-latency read port onto the shared bus; idle bus value is zero.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    BUS_OE  = cpu_rd;
    BUS_OUT = '0;
    if (cpu_rd) BUS_OUT = mem[mar];
  end

  // While we drive the bus, the bus value is our own read data; that is what
  // makes read + MAR_LOAD an indirect address step.
  assign bus_val = cpu_rd ? BUS_OUT : BUS_IN;

  // Loader next-state; a low LD_MODE aborts from any state.
  always_comb begin
    ld_state_nxt = ld_state;
    case (ld_state)
      LD_IDLE: if (LD_MODE) ld_state_nxt = LD_HI;
      LD_HI:   if (ld_hs) ld_state_nxt = LD_LO;
      LD_LO:   if (ld_hs) ld_state_nxt = LD_WR;
      LD_WR:   ld_state_nxt = LD_HI;
      default: ld_state_nxt = LD_IDLE;
    endcase
    if (!LD_MODE) ld_state_nxt = LD_IDLE;
  end

  // Control state: MAR, loader FSM, loader counters and sticky flags.
  always_ff @(posedge CLK or negedge RST) begin
    // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
    if (!RST) begin
      mar          <= '0;
      ld_state     <= LD_IDLE;
      ld_addr      <= '0;
      hi_byte      <= '0;
      lo_byte      <= '0;
      LD_WORDS     <= '0;
      LD_WRAP      <= 1'b0;
      ERR_CONFLICT <= 1'b0;
    end else begin
      ld_state <= ld_state_nxt;
      if (err_set) ERR_CONFLICT <= 1'b1;
      if (!LD_MODE && MAR_LOAD) mar <= bus_val[ADDR_W-1:0];

      if (ld_state == LD_IDLE && LD_MODE) begin
        ld_addr  <= '0;
        LD_WORDS <= '0;
        LD_WRAP  <= 1'b0;
      end
      if (ld_hs && ld_state == LD_HI) hi_byte <= LD_DATA;
      if (ld_hs && ld_state == LD_LO) lo_byte <= LD_DATA;
      if (ld_wr) begin
        ld_addr <= ld_addr + ADDR_W'(1);
        if (ld_addr == {ADDR_W{1'b1}}) LD_WRAP <= 1'b1;
        if (LD_WORDS != WORDS_MAX) LD_WORDS <= LD_WORDS + (ADDR_W+1)'(1);
      end
    end
  end

  // RAM write port shared by the loader and the CPU; the two never overlap
  // because LD_MODE selects exactly one owner.
  always_ff @(posedge CLK) begin
    // NOTE: RAM has no reset; contents survive RST and only the control state is cleared.
    if (ld_wr)       mem[ld_addr] <= DATA_W'({hi_byte, lo_byte});
    else if (cpu_wr) mem[mar]     <= bus_val;
  end

endmodule
